// File: rtl/regfile_writeback_queue_if.sv
// Handshake and register-file write-port bundle for regfile_writeback_queue.
// The slave side is the queue itself; the master side is its surroundings.
interface regfile_writeback_queue_if #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = 32,
  parameter int unsigned AW    = 5
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic            alu_valid;
  logic [AW-1:0]   alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            alu_ready;
  logic            mem_valid;
  logic [AW-1:0]   mem_rd;
  logic [XLEN-1:0] mem_data;
  logic            mem_ready;
  logic            rf_load;
  logic [AW-1:0]   rf_addrD;
  logic [XLEN-1:0] rf_D;
  logic [CW-1:0]   count;
  logic            full;
  logic [AW-1:0]   q_addrA;
  logic [AW-1:0]   q_addrB;
  logic            q_hitA;
  logic            q_hitB;
  logic [XLEN-1:0] q_dataA;
  logic [XLEN-1:0] q_dataB;

  modport master (
    output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data, q_addrA, q_addrB,
    input  alu_ready, mem_ready, rf_load, rf_addrD, rf_D, count, full,
    input  q_hitA, q_hitB, q_dataA, q_dataB
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data, q_addrA, q_addrB,
    output alu_ready, mem_ready, rf_load, rf_addrD, rf_D, count, full,
    output q_hitA, q_hitB, q_dataA, q_dataB
  );
endinterface

// File: rtl/regfile_writeback_queue.sv
// In-order writeback FIFO merging ALU and load results onto the register file write port.
// Define WBQ_BYPASS_EN to forward pending results to the q_addrA/q_addrB read ports.
module regfile_writeback_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = 32,
  parameter int unsigned AW    = 5
) (
  input logic                    Clk,
  input logic                    Reset,
  regfile_writeback_queue_if.slave bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [PW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d, alu_slot;
  logic [CW-1:0]   count_q, count_d, free;
  logic [AW-1:0]   rd_q   [DEPTH];
  logic [XLEN-1:0] data_q [DEPTH];
  logic [AW-1:0]   last_rd_q;
  logic [XLEN-1:0] last_data_q;
  logic            mem_push, alu_push, pop;
  logic            mem_rdy, alu_rdy;

  // Free space uses the registered count only; a same-cycle pop is not credited.
  assign free    = CW'(DEPTH) - count_q;
  assign mem_rdy = (free >= CW'(1));
  assign alu_rdy = bus.mem_valid ? (free >= CW'(2)) : (free >= CW'(1));

  // Writes to x0 complete the handshake but are never stored.
  assign mem_push = bus.mem_valid && mem_rdy && (bus.mem_rd != '0);
  assign alu_push = bus.alu_valid && alu_rdy && (bus.alu_rd != '0);
  assign pop      = (count_q != '0);

  always_comb begin
    alu_slot = wptr_q + PW'(mem_push);
    wptr_d   = wptr_q + PW'(mem_push) + PW'(alu_push);
    rptr_d   = rptr_q + PW'(pop);
    count_d  = count_q + CW'(mem_push) + CW'(alu_push) - CW'(pop);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      last_rd_q   <= '0;
      last_data_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      if (pop) begin
        last_rd_q   <= rd_q[rptr_q];
        last_data_q <= data_q[rptr_q];
      end
    end
  end

  // Slot contents need no reset: only entries below count are ever observed.
  always_ff @(posedge Clk) begin
    if (mem_push) begin
      rd_q[wptr_q]   <= bus.mem_rd;
      data_q[wptr_q] <= bus.mem_data;
    end
    if (alu_push) begin
      rd_q[alu_slot]   <= bus.alu_rd;
      data_q[alu_slot] <= bus.alu_data;
    end
  end

  assign bus.mem_ready = mem_rdy;
  assign bus.alu_ready = alu_rdy;
  assign bus.rf_load   = pop;
  assign bus.rf_addrD  = pop ? rd_q[rptr_q] : last_rd_q;
  assign bus.rf_D      = pop ? data_q[rptr_q] : last_data_q;
  assign bus.count     = count_q;
  assign bus.full      = (count_q == CW'(DEPTH));

`ifdef WBQ_BYPASS_EN
  logic            hit_a, hit_b;
  logic [XLEN-1:0] fwd_a, fwd_b;
  logic [PW-1:0]   idx;

  // Walk oldest to youngest so the youngest match wins.
  always_comb begin
    hit_a = 1'b0;
    hit_b = 1'b0;
    fwd_a = '0;
    fwd_b = '0;
    idx   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = rptr_q + PW'(i);
      if (CW'(i) < count_q) begin
        if ((bus.q_addrA != '0) && (rd_q[idx] == bus.q_addrA)) begin
          hit_a = 1'b1;
          fwd_a = data_q[idx];
        end
        if ((bus.q_addrB != '0) && (rd_q[idx] == bus.q_addrB)) begin
          hit_b = 1'b1;
          fwd_b = data_q[idx];
        end
      end
    end
  end

  assign bus.q_hitA  = hit_a;
  assign bus.q_hitB  = hit_b;
  assign bus.q_dataA = fwd_a;
  assign bus.q_dataB = fwd_b;
`else
  logic unused_q_addr;
  assign unused_q_addr = ^{bus.q_addrA, bus.q_addrB};
  assign bus.q_hitA    = 1'b0;
  assign bus.q_hitB    = 1'b0;
  assign bus.q_dataA   = '0;
  assign bus.q_dataB   = '0;
`endif

endmodule
